// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline: ID/EX, EX/MEM, MEM/WB control stages with load-use stall, branch flush,
// operand forwarding selects and saturating stall/flush counters.
module ctrl_pipeline #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_reg_write,
  input  logic              id_mem_write,
  input  logic              id_branch,
  input  logic              id_alu_src,
  input  logic              id_result_src,
  input  logic [1:0]        id_alu_op,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              ex_zero,
  output logic              stall_fd,
  output logic              flush_d,
  output logic              pc_src,
  output logic              ex_alu_src,
  output logic [1:0]        ex_alu_op,
  output logic              mem_mem_write,
  output logic              wb_reg_write,
  output logic              wb_result_src,
  output logic [REG_AW-1:0] wb_rd,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_write;
    logic              branch;
    logic              alu_src;
    logic              result_src;
    logic [1:0]        alu_op;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
  } e_t;
  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_write;
    logic              result_src;
    logic [REG_AW-1:0] rd;
  } mw_t;
  e_t               e_q, e_d;
  mw_t              m_q, m_d, w_q;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
    return (m_q.valid && m_q.reg_write && m_q.rd != '0 && m_q.rd == rs) ? 2'b10 :
           (w_q.valid && w_q.reg_write && w_q.rd != '0 && w_q.rd == rs) ? 2'b01 : 2'b00;
  endfunction
  always_comb begin
    stall_fd    = id_valid && e_q.valid && e_q.result_src && e_q.rd != '0 &&
                  (e_q.rd == id_rs1 || e_q.rd == id_rs2);
    pc_src      = e_q.valid && e_q.branch && ex_zero;
    flush_d     = pc_src;
    e_d         = (stall_fd || flush_d) ? '0 :
                  {id_valid, id_reg_write, id_mem_write, id_branch, id_alu_src, id_result_src,
                   id_alu_op, id_rs1, id_rs2, id_rd};
    m_d         = {e_q.valid, e_q.reg_write, e_q.mem_write, e_q.result_src, e_q.rd};
    stall_cnt_d = stall_cnt_q + CNT_W'(stall_fd && !(&stall_cnt_q));
    flush_cnt_d = flush_cnt_q + CNT_W'(flush_d && !(&flush_cnt_q));
    fwd_a       = fwd_sel(e_q.rs1);
    fwd_b       = fwd_sel(e_q.rs2);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      e_q         <= '0;
      m_q         <= '0;
      w_q         <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      e_q         <= e_d;
      m_q         <= m_d;
      w_q         <= m_q;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  assign ex_alu_src    = e_q.valid && e_q.alu_src;
  assign ex_alu_op     = e_q.valid ? e_q.alu_op : 2'b00;
  assign mem_mem_write = m_q.valid && m_q.mem_write;
  assign wb_reg_write  = w_q.valid && w_q.reg_write;
  assign wb_result_src = w_q.valid && w_q.result_src;
  assign wb_rd         = w_q.valid ? w_q.rd : '0;
  assign stall_cnt     = stall_cnt_q;
  assign flush_cnt     = flush_cnt_q;
endmodule

// File: tb/tb_ctrl_pipeline.sv
// tb_ctrl_pipeline: directed checks of staging, forwarding, stall, flush and counters.
module tb_ctrl_pipeline;
  logic       clk = 1'b0, rst = 1'b1;
  logic       id_valid, id_reg_write, id_mem_write, id_branch, id_alu_src, id_result_src;
  logic [1:0] id_alu_op;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       ex_zero;
  logic       stall_fd, flush_d, pc_src, ex_alu_src, mem_mem_write, wb_reg_write, wb_result_src;
  logic [1:0] ex_alu_op, fwd_a, fwd_b;
  logic [4:0] wb_rd;
  logic [7:0] stall_cnt, flush_cnt;
  int         passed = 0, total = 0;

  ctrl_pipeline #(.REG_AW(5), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_reg_write(id_reg_write),
    .id_mem_write(id_mem_write), .id_branch(id_branch), .id_alu_src(id_alu_src),
    .id_result_src(id_result_src), .id_alu_op(id_alu_op), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .ex_zero(ex_zero), .stall_fd(stall_fd), .flush_d(flush_d), .pc_src(pc_src),
    .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op), .mem_mem_write(mem_mem_write),
    .wb_reg_write(wb_reg_write), .wb_result_src(wb_result_src), .wb_rd(wb_rd),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic id_set(input logic v, rw, mw, br, as, rs, input logic [1:0] op,
                        input logic [4:0] r1, r2, rd);
    {id_valid, id_reg_write, id_mem_write, id_branch, id_alu_src, id_result_src} = {v, rw, mw, br, as, rs};
    id_alu_op = op;
    id_rs1 = r1;
    id_rs2 = r2;
    id_rd = rd;
  endtask

  task automatic i_add(input logic [4:0] rd, r1, r2); id_set(1, 1, 0, 0, 0, 0, 2'b10, r1, r2, rd); endtask
  task automatic i_lw(input logic [4:0] rd, r1);     id_set(1, 1, 0, 0, 1, 1, 2'b00, r1, 5'd0, rd); endtask
  task automatic i_sw(input logic [4:0] r2, r1);     id_set(1, 0, 1, 0, 1, 0, 2'b00, r1, r2, 5'd0); endtask
  task automatic i_beq(input logic [4:0] r1, r2);    id_set(1, 0, 0, 1, 0, 0, 2'b01, r1, r2, 5'd0); endtask
  task automatic i_nop;                               id_set(1, 1, 0, 0, 1, 0, 2'b00, 5'd0, 5'd0, 5'd0); endtask

  initial begin
    id_set(0, 0, 0, 0, 0, 0, 2'b00, 5'd0, 5'd0, 5'd0);
    ex_zero = 1'b0;
    #2;
    chk("rst_stall", 32'(stall_fd), 0);
    chk("rst_fwd", 32'({fwd_a, fwd_b}), 0);
    chk("rst_cnt", 32'({stall_cnt, flush_cnt}), 0);
    tick;
    rst = 1'b0;
    // back-to-back RAW
    i_add(5, 1, 2); tick;
    chk("add_ex_op", 32'(ex_alu_op), 2);
    i_sub_like: begin id_set(1, 1, 0, 0, 0, 0, 2'b10, 5'd5, 5'd3, 5'd6); end
    #1 chk("raw_pre_fwd", 32'(fwd_a), 0);
    tick; i_nop; #1;
    chk("raw_fwd_a_mem", 32'(fwd_a), 2);
    chk("raw_fwd_b_none", 32'(fwd_b), 0);
    tick;
    chk("wb_rd_add", 32'(wb_rd), 5);
    chk("wb_rw_add", 32'({wb_reg_write, wb_result_src}), 2);
    // one nop between
    i_add(5, 1, 2); tick; i_nop; tick; id_set(1, 1, 0, 0, 0, 0, 2'b10, 5'd5, 5'd3, 5'd6); tick;
    chk("raw1_fwd_a_wb", 32'(fwd_a), 1);
    // two nops between
    i_add(5, 1, 2); tick; i_nop; tick; i_nop; tick; id_set(1, 1, 0, 0, 0, 0, 2'b10, 5'd5, 5'd3, 5'd6); tick;
    chk("raw2_fwd_a_none", 32'(fwd_a), 0);
    // rs2 forwarding and MEM-over-WB priority
    i_add(5, 1, 2); tick; id_set(1, 1, 0, 0, 0, 0, 2'b10, 5'd3, 5'd5, 5'd6); tick;
    chk("fwd_b_mem", 32'({fwd_a, fwd_b}), 32'b0010);
    i_add(5, 1, 2); tick; i_add(5, 5, 3); tick; id_set(1, 1, 0, 0, 0, 0, 2'b10, 5'd5, 5'd4, 5'd6); tick;
    chk("fwd_mem_prio", 32'(fwd_a), 2);
    // load-use via rs1
    i_lw(7, 1); tick; i_add(8, 7, 2); #1;
    chk("lu_stall", 32'({stall_fd, flush_d, pc_src}), 32'b100);
    tick;
    chk("lu_one_cycle", 32'(stall_fd), 0);
    chk("lu_bubble", 32'({ex_alu_src, ex_alu_op}), 0);
    chk("lu_cnt1", 32'(stall_cnt), 1);
    tick;
    chk("lu_fwd_wb", 32'(fwd_a), 1);
    chk("lu_add_in_ex", 32'(ex_alu_op), 2);
    chk("lu_wb_load", 32'({wb_result_src, wb_rd}), 32'h27);
    // load-use via rs2
    i_lw(7, 1); tick; i_add(8, 2, 7); #1;
    chk("lu_rs2_stall", 32'(stall_fd), 1);
    tick;
    chk("lu_cnt2", 32'(stall_cnt), 2);
    tick;
    // taken branch
    i_beq(1, 2); tick; i_add(10, 1, 2); ex_zero = 1'b1; #1;
    chk("br_taken", 32'({pc_src, flush_d, stall_fd}), 32'b110);
    tick; ex_zero = 1'b0; #1;
    chk("br_bubble", 32'({ex_alu_src, ex_alu_op, flush_d}), 0);
    chk("br_cnt1", 32'(flush_cnt), 1);
    // not-taken branch
    i_beq(1, 2); tick; i_add(10, 1, 2); #1;
    chk("br_not_taken", 32'({pc_src, flush_d}), 0);
    tick;
    chk("br_nt_add_ex", 32'(ex_alu_op), 2);
    chk("br_nt_cnt", 32'(flush_cnt), 1);
    // x0 never stalls or forwards
    i_lw(0, 1); tick; i_add(9, 0, 0); #1;
    chk("x0_no_stall", 32'(stall_fd), 0);
    tick; i_add(0, 1, 2); tick; i_add(9, 0, 3); tick;
    chk("x0_no_fwd", 32'({fwd_a, fwd_b}), 0);
    // store reaches MEM
    i_sw(2, 1); tick; i_nop; tick;
    chk("sw_mem", 32'(mem_mem_write), 1);
    tick;
    chk("sw_gone", 32'(mem_mem_write), 0);
    // reset mid-pipeline
    i_add(5, 1, 2); tick; i_lw(7, 1); tick; i_add(8, 7, 2); #1;
    chk("mid_pre_stall", 32'({stall_fd, ex_alu_src}), 32'b11);
    rst = 1'b1; #1;
    chk("mid_rst_ctrl", 32'({stall_fd, flush_d, pc_src, ex_alu_src, ex_alu_op, mem_mem_write}), 0);
    chk("mid_rst_wb", 32'({wb_reg_write, wb_result_src, wb_rd}), 0);
    chk("mid_rst_fwd", 32'({fwd_a, fwd_b}), 0);
    chk("mid_rst_cnt", 32'({stall_cnt, flush_cnt}), 0);
    rst = 1'b0;
    i_add(11, 1, 2); tick;
    chk("post_rst_ex", 32'({ex_alu_op, stall_fd}), 32'b100);
    // saturation: lw x7,0(x7) held in ID stalls every other cycle
    i_lw(7, 7);
    for (int i = 0; i < 500; i++) tick;
    chk("sat_cnt250", 32'(stall_cnt), 250);
    for (int i = 0; i < 20; i++) tick;
    chk("sat_hold", 32'(stall_cnt), 255);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ctrl_pipeline.md
# ctrl_pipeline

Carries the decoder's control bundle and destination register through the ID/EX, EX/MEM and MEM/WB stages of the five-stage RISC-V core. It also owns hazard handling:
- load-use stall detection,
- taken-branch flush,
- EX-stage operand forwarding selects,
- saturating stall/flush event counters.

It sits between the main decoder (ID) and the EX/MEM/WB datapath.

## Interface
- REG_AW, 5, register address width
- CNT_W, 16, event counter width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID stage holds a real instruction
- id_reg_write, id_mem_write, id_branch, id_alu_src, id_result_src  in  1 each  decoder controls for the instruction in ID
- id_alu_op  in  2  decoder ALUOp
- id_rs1, id_rs2, id_rd  in  REG_AW  register fields of the instruction in ID
- ex_zero  in  1  ALU zero flag of the instruction in EX
- stall_fd  out  1  hold PC and IF/ID this cycle
- flush_d  out  1  squash IF/ID contents this cycle
- pc_src  out  1  select branch target for next PC
- ex_alu_src  out  1  EX-stage control
- ex_alu_op  out  2  EX-stage control
- mem_mem_write  out  1  MEM-stage control
- wb_reg_write, wb_result_src  out  1 each  WB-stage controls
- wb_rd  out  REG_AW  WB-stage destination register
- fwd_a, fwd_b  out  2  EX operand select: 00 register file, 10 MEM ALU result, 01 WB result
- stall_cnt, flush_cnt  out  CNT_W  event counters

## Operation
- Stage registers:
  - E holds valid, the full control bundle, rs1, rs2 and rd.
  - M and W hold valid, reg_write, mem_write, result_src and rd.
  - Stages advance every clock: W<=M, M<=E, E<=ID or a bubble.
- Bubble: valid=0, all controls 0, rd/rs 0.
- Stage outputs (ex_*, mem_*, wb_*) are the stored control values gated by that stage's valid.
- Load-use condition, all of the following:
  - id_valid & E.valid & E.result_src & E.rd!=0;
  - (E.rd==id_rs1 | E.rd==id_rs2).
  - rs2 is compared for every opcode; a conservative false stall is accepted.
- Load-use response: stall_fd=1, and E loads a bubble at the next edge.
- Branch: pc_src = E.valid & E.branch & ex_zero.
  - When pc_src=1: flush_d=1 and E loads a bubble, squashing the instruction in ID.
  - The branch itself still moves E->M.
- Load-use and taken branch are mutually exclusive, since E holds one instruction (branch has result_src=0). No priority logic is needed.
- Forwarding for fwd_a (fwd_b identical with E.rs2):
  - 10 if M.valid & M.reg_write & M.rd!=0 & M.rd==E.rs1;
  - else 01 if W.valid & W.reg_write & W.rd!=0 & W.rd==E.rs1;
  - else 00.
  - MEM has priority over WB.
- x0 never triggers a stall or a forward.
- An instruction decoded as all-zero controls (unknown opcode) flows as valid with no side effects.
- Counters: stall_cnt +1 on each cycle with stall_fd=1; flush_cnt +1 on each cycle with flush_d=1. Both saturate at all-ones.

## Timing
- Reset (async, immediate on rst rising):
  - all stage valids, controls, rd/rs and counters = 0;
  - stall_fd=0, flush_d=0, pc_src=0, fwd_a=fwd_b=00.
  - Reset mid-pipeline discards all in-flight instructions; the first edge after rst deasserts captures ID normally.
- Combinational outputs from registered state: stall_fd, flush_d, pc_src, fwd_a, fwd_b, all same cycle as the causing condition. Only id_* (stall) and ex_zero (branch) enter these paths.
- Control latency: id_* at edge N appears on ex_* after N, on mem_* after N+1, on wb_* after N+2.
- A load-use stall lasts exactly 1 cycle; the following cycle E is a bubble, so the condition clears.
- Counters update at the edge ending the counted cycle.

## Test plan
- Reset: run a mixed stream, pulse rst mid-cycle -> all outputs 0 before the next edge, counters 0, next instruction enters cleanly.
- RAW forwarding: add x5,x1,x2 then sub x6,x5,x3 -> fwd_a=10 while sub is in E. With one nop between -> fwd_a=01. With two nops -> 00.
- Load-use: lw x7 then add x8,x7,x2:
  - stall_fd=1 for exactly one cycle;
  - next cycle ex_* all 0;
  - then fwd_a=01 with add in E;
  - stall_cnt=1.
- Branch with beq in E:
  - ex_zero=1 -> pc_src=1, flush_d=1 that cycle, following E bubble, flush_cnt=1;
  - ex_zero=0 -> pc_src=0, no flush.
- x0: lw x0 followed by add x9,x0,x0 -> no stall; add x0 followed by a use of x0 -> fwd 00.
- Saturation: force 2^16+5 load-use stalls -> stall_cnt holds 0xFFFF.
